icg_enable_ctrl: RTL and testbench

ICG_ENABLE_CTRL -- requirements
Module: icg_enable_ctrl

---
 rtl/icg_enable_ctrl.sv | 174 +++++++++++++++++
 tb/tb_icg_enable_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icg_enable_ctrl.sv
// -----------------------------------------------------------------------------
// icg_enable_ctrl
//
// Purpose:
//   Generates the registered enable for a downstream integrated clock-gating
//   cell. While the gated stage keeps reporting activity the enable stays high.
//   After IDLE_CYCLES consecutive idle samples the enable drops and the block
//   sits in GATED. The first activity sample reopens the clock. The clock then
//   stays on for at least WAKE_CYCLES cycles before idle detection starts again.
//   force_on overrides everything and holds the clock running.
//
// Parameters:
//   IDLE_CYCLES  consecutive act_in=0 samples before gating      (1..255)
//   WAKE_CYCLES  minimum enable-on cycles after a wake           (1..15)
//
// Ports:
//   clk        in   free-running clock, rising-edge active
//   rst_n      in   asynchronous active-low reset (deassertion synchronised
//                   outside this block)
//   act_in     in   activity from the data source, high = work this cycle
//   force_on   in   keep the gated clock running (priority over act_in)
//   en         out  registered ICG enable
//   gated      out  high exactly while in GATED
//   state      out  FSM state: RUN=0, COUNT=1, GATED=2, WAKE=3
//   gate_cnt   out  saturating count of entries into GATED (only when
//                   ICG_CTRL_STATS_EN is defined)
//
// Configuration macro:
//   ICG_CTRL_STATS_EN  adds the gate_cnt port and its 16-bit saturating
//                      counter. Undefined by default.
// -----------------------------------------------------------------------------
module icg_enable_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        act_in,
    input  logic        force_on,
    output logic        en,
    output logic        gated,
    output logic [1:0]  state
`ifdef ICG_CTRL_STATS_EN
    ,
    output logic [15:0] gate_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_t;

    // Terminal counts. The idle counter only ever holds 1..IDLE_CYCLES-1 and
    // the wake counter 0..WAKE_CYCLES-1, so neither can wrap.
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);
    localparam bit         IDLE_ONE  = (IDLE_CYCLES == 1);

    state_t      state_q;
    logic [7:0]  idle_cnt_q;
    logic [3:0]  wake_cnt_q;
    logic        en_q;
    logic        enter_gated_d;

    // High on the edge that samples the IDLE_CYCLES-th consecutive idle cycle.
    // Shared by the FSM and the statistics counter so both agree exactly.
    always_comb begin
        enter_gated_d = 1'b0;
        if (!force_on && !act_in) begin
            if (state_q == RUN && IDLE_ONE) begin
                enter_gated_d = 1'b1;
            end else if (state_q == COUNT && idle_cnt_q == IDLE_LAST) begin
                enter_gated_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            idle_cnt_q <= 8'd0;
            wake_cnt_q <= 4'd0;
            en_q       <= 1'b1;
        end else if (force_on) begin
            state_q    <= RUN;
            idle_cnt_q <= 8'd0;
            wake_cnt_q <= 4'd0;
            en_q       <= 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (enter_gated_d) begin
                        state_q    <= GATED;
                        idle_cnt_q <= 8'd0;
                        en_q       <= 1'b0;
                    end else if (!act_in) begin
                        state_q    <= COUNT;
                        idle_cnt_q <= 8'd1;
                        en_q       <= 1'b1;
                    end else begin
                        idle_cnt_q <= 8'd0;
                        en_q       <= 1'b1;
                    end
                end
                COUNT: begin
                    if (act_in) begin
                        state_q    <= RUN;
                        idle_cnt_q <= 8'd0;
                        en_q       <= 1'b1;
                    end else if (enter_gated_d) begin
                        state_q    <= GATED;
                        idle_cnt_q <= 8'd0;
                        en_q       <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                        en_q       <= 1'b1;
                    end
                end
                GATED: begin
                    if (act_in) begin
                        state_q    <= WAKE;
                        wake_cnt_q <= 4'd0;
                        en_q       <= 1'b1;
                    end else begin
                        en_q       <= 1'b0;
                    end
                end
                WAKE: begin
                    // Activity is ignored here: the clock stays on for the
                    // full wake window, then idle detection restarts in RUN.
                    en_q <= 1'b1;
                    if (wake_cnt_q == WAKE_LAST) begin
                        state_q    <= RUN;
                        wake_cnt_q <= 4'd0;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    idle_cnt_q <= 8'd0;
                    wake_cnt_q <= 4'd0;
                    en_q       <= 1'b1;
                end
            endcase
        end
    end

    assign en    = en_q;
    assign gated = (state_q == GATED);
    assign state = state_q;

`ifdef ICG_CTRL_STATS_EN
    logic [15:0] gate_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q <= 16'd0;
        end else if (enter_gated_d) begin
            gate_cnt_q <= sat_inc16(gate_cnt_q);
        end
    end

    assign gate_cnt = gate_cnt_q;
`endif

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icg_enable_ctrl
//
// Two instances share clk and rst_n:
//   dut   IDLE_CYCLES=4, WAKE_CYCLES=2  (main scenarios)
//   dut1  IDLE_CYCLES=1, WAKE_CYCLES=1  (direct gating, gate_cnt saturation)
// Expected output tuples are pushed to a queue before each stimulus cycle and
// popped for comparison once the DUT has taken the edge.
// -----------------------------------------------------------------------------
module tb_icg_enable_ctrl;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_GATED = 2'd2;
    localparam logic [1:0] S_WAKE  = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       act, frc, act1, frc1;
    logic       en, gated, en1, gated1;
    logic [1:0] state, state1;
`ifdef ICG_CTRL_STATS_EN
    logic [15:0] gcnt, gcnt1;
`endif

    icg_enable_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .act_in   (act),
        .force_on (frc),
        .en       (en),
        .gated    (gated),
        .state    (state)
`ifdef ICG_CTRL_STATS_EN
        ,
        .gate_cnt (gcnt)
`endif
    );

    icg_enable_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .act_in   (act1),
        .force_on (frc1),
        .en       (en1),
        .gated    (gated1),
        .state    (state1)
`ifdef ICG_CTRL_STATS_EN
        ,
        .gate_cnt (gcnt1)
`endif
    );

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       gt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cnt_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Expected outputs for a state: clock enabled everywhere except GATED.
    function automatic exp_t mk(input logic [1:0] s);
        exp_t r;
        r.st = s;
        r.en = (s != S_GATED);
        r.gt = (s == S_GATED);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; act = 1'b0; frc = 1'b0; act1 = 1'b1; frc1 = 1'b0;
        repeat (2) tick();
        exp_q.push_back(mk(S_RUN));
        exp_q.push_back(mk(S_RUN));
        e = exp_q.pop_front();
        n_cmp++;
        if ({state, en, gated} !== e) begin
            n_bad++;
            $display("FAIL reset_dut: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                     state, en, gated, e.st, e.en, e.gt);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({state1, en1, gated1} !== e) begin
            n_bad++;
            $display("FAIL reset_dut1: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                     state1, en1, gated1, e.st, e.en, e.gt);
        end
`ifdef ICG_CTRL_STATS_EN
        n_cmp++;
        if (gcnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_gate_cnt: got %0d, want 0", gcnt);
        end
`endif
        rst_n = 1'b1;
    endtask

    // act_in=0 from RUN: COUNT x3 then GATED on the 4th edge, and stays gated.
    task automatic test_idle_gating();
        logic [1:0] exp_s [5] = '{S_COUNT, S_COUNT, S_COUNT, S_GATED, S_GATED};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(exp_s[i]));
            act = 1'b0; frc = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, en, gated} !== e) begin
                n_bad++;
                $display("FAIL idle_gating[%0d]: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                         i, state, en, gated, e.st, e.en, e.gt);
            end
        end
`ifdef ICG_CTRL_STATS_EN
        n_cmp++;
        if (gcnt !== 16'd1) begin
            n_bad++;
            $display("FAIL idle_gating_gate_cnt: got %0d, want 1", gcnt);
        end
`endif
    endtask

    // One activity pulse at idle count 3 of 4 restarts idle detection.
    task automatic test_act_pulse();
        logic       frc_s [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       act_s [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] exp_s [9] = '{S_RUN, S_COUNT, S_COUNT, S_COUNT, S_RUN,
                                  S_COUNT, S_COUNT, S_COUNT, S_GATED};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(mk(exp_s[i]));
            act = act_s[i]; frc = frc_s[i];
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, en, gated} !== e) begin
                n_bad++;
                $display("FAIL act_pulse[%0d]: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                         i, state, en, gated, e.st, e.en, e.gt);
            end
        end
    endtask

    // Wake from GATED: two WAKE cycles, RUN, COUNT x3, GATED; then a wake
    // with act_in held high, which must not extend or shorten WAKE.
    task automatic test_wake();
        logic       act_s [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_s [11] = '{S_WAKE, S_WAKE, S_RUN, S_COUNT, S_COUNT, S_COUNT,
                                   S_GATED, S_WAKE, S_WAKE, S_RUN, S_RUN};
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(mk(exp_s[i]));
            act = act_s[i]; frc = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, en, gated} !== e) begin
                n_bad++;
                $display("FAIL wake[%0d]: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                         i, state, en, gated, e.st, e.en, e.gt);
            end
        end
    endtask

    // force_on from GATED and WAKE, and no gating while it is held.
    task automatic test_force();
        logic       frc_s [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       act_s [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] exp_s [16] = '{S_COUNT, S_COUNT, S_COUNT, S_GATED,
                                   S_RUN, S_RUN, S_RUN, S_RUN, S_RUN, S_RUN,
                                   S_COUNT, S_COUNT, S_COUNT, S_GATED, S_WAKE, S_RUN};
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(mk(exp_s[i]));
            act = act_s[i]; frc = frc_s[i];
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, en, gated} !== e) begin
                n_bad++;
                $display("FAIL force[%0d]: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                         i, state, en, gated, e.st, e.en, e.gt);
            end
        end
        frc = 1'b0;
    endtask

    // Reset applied between edges while GATED takes effect immediately; after
    // release the first edge evaluates from RUN.
    task automatic test_async_reset();
        logic [1:0] exp_s [4] = '{S_COUNT, S_COUNT, S_COUNT, S_GATED};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(exp_s[i]));
            act = 1'b0; frc = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, en, gated} !== e) begin
                n_bad++;
                $display("FAIL async_reset_pre[%0d]: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                         i, state, en, gated, e.st, e.en, e.gt);
            end
        end
        #2;
        exp_q.push_back(mk(S_RUN));
        rst_n = 1'b0;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if ({state, en, gated} !== e) begin
            n_bad++;
            $display("FAIL async_reset_now: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                     state, en, gated, e.st, e.en, e.gt);
        end
`ifdef ICG_CTRL_STATS_EN
        n_cmp++;
        if (gcnt !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset_gate_cnt: got %0d, want 0", gcnt);
        end
`endif
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(exp_s[i]));
            act = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({state, en, gated} !== e) begin
                n_bad++;
                $display("FAIL async_reset_post[%0d]: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                         i, state, en, gated, e.st, e.en, e.gt);
            end
        end
    endtask

    // IDLE_CYCLES=1 gates on the very first idle sample; WAKE_CYCLES=1.
    task automatic test_idle_one();
        logic       act_s [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_s [8] = '{S_GATED, S_WAKE, S_RUN, S_GATED, S_GATED,
                                  S_WAKE, S_RUN, S_RUN};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(exp_s[i]));
            act1 = act_s[i]; frc1 = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if ({state1, en1, gated1} !== e) begin
                n_bad++;
                $display("FAIL idle_one[%0d]: got st=%0d en=%b gated=%b, want st=%0d en=%b gated=%b",
                         i, state1, en1, gated1, e.st, e.en, e.gt);
            end
        end
    endtask

`ifdef ICG_CTRL_STATS_EN
    // Each pair of cycles enters GATED once (idle edge) and leaves via force_on.
    task automatic test_saturation();
        logic [15:0] want;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        act1 = 1'b0;
        for (int n = 1; n <= 65540; n++) begin
            if (n == 1 || n == 65534 || n == 65535 || n == 65540)
                cnt_q.push_back((n > 65535) ? 16'hFFFF : 16'(n));
            frc1 = 1'b0;
            tick();
            if (n == 1 || n == 65534 || n == 65535 || n == 65540) begin
                want = cnt_q.pop_front();
                n_cmp++;
                if (gcnt1 !== want || state1 !== S_GATED) begin
                    n_bad++;
                    $display("FAIL saturation[%0d]: got cnt=%0d st=%0d, want cnt=%0d st=%0d",
                             n, gcnt1, state1, want, S_GATED);
                end
            end
            frc1 = 1'b1;
            tick();
        end
        frc1 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_gating();
        test_act_pulse();
        test_wake();
        test_force();
        test_async_reset();
        test_idle_one();
`ifdef ICG_CTRL_STATS_EN
        test_saturation();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
